// File: rtl/ndp_xbar_rr.sv
// NUM_IN x NUM_OUT packet-word crossbar: per-input FWFT FIFOs feeding per-output
// round-robin arbiters and registered output stages with downstream backpressure.

module ndp_xbar_rr_fifo #(
    parameter int W  = 8,
    parameter int DB = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         rdy
);
    localparam int D = 1 << DB;

    logic [W-1:0]  mem [D];
    logic [DB-1:0] wp, rp;
    logic [DB:0]   cnt;
    logic          wr_en, pop_en;

    assign empty  = (cnt == '0);
    assign wr_en  = wr && (cnt != (DB+1)'(D));
    assign pop_en = pop && !empty;
    // One slot of slack so upstream sees backpressure before the FIFO is full
    assign rdy    = (cnt < (DB+1)'(D-1));
    assign head   = mem[rp];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wp] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_en)  wp <= wp + 1'b1;
            if (pop_en) rp <= rp + 1'b1;
            cnt <= cnt + (DB+1)'(wr_en) - (DB+1)'(pop_en);
        end
    end
endmodule

module ndp_xbar_rr #(
    parameter int DATA_WIDTH      = 480,
    parameter int CTRL_WIDTH      = 32,
    parameter int NUM_IN          = 4,
    parameter int NUM_OUT         = 8,
    parameter int DST_LSB         = 0,
    parameter int DST_WIDTH       = 3,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_IN-1:0]              in_valid,
    input  logic [NUM_IN*CTRL_WIDTH-1:0]   in_ctl,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   in_data,
    output logic [NUM_IN-1:0]              in_rdy,
    input  logic [NUM_OUT-1:0]             out_rdy,
    output logic [NUM_OUT-1:0]             out_wr,
    output logic [NUM_OUT*CTRL_WIDTH-1:0]  out_ctl,
    output logic [NUM_OUT*DATA_WIDTH-1:0]  out_data,
    output logic [15:0]                    drop_cnt
);
    localparam int W  = CTRL_WIDTH + DATA_WIDTH;
    localparam int PW = $clog2(NUM_IN);

    logic [NUM_IN-1:0][W-1:0]          head;
    logic [NUM_IN-1:0][DST_WIDTH-1:0]  dst;
    logic [NUM_IN-1:0]                 empty, drop, pop;
    logic [NUM_OUT-1:0][NUM_IN-1:0]    req;
    logic [NUM_OUT-1:0]                free, gnt_any;
    logic [NUM_OUT-1:0][PW-1:0]        gnt_idx, rr_ptr;
    logic [NUM_OUT-1:0][W-1:0]         out_q;
    logic [15:0]                       ndrop;
    logic [16:0]                       drop_sum;

    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_IN) s = s - NUM_IN;
        return PW'(s);
    endfunction

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        ndp_xbar_rr_fifo #(.W(W), .DB(FIFO_DEPTH_BITS)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wr    (in_valid[i]),
            .wdata ({in_ctl[i*CTRL_WIDTH +: CTRL_WIDTH], in_data[i*DATA_WIDTH +: DATA_WIDTH]}),
            .pop   (pop[i]),
            .head  (head[i]),
            .empty (empty[i]),
            .rdy   (in_rdy[i])
        );
        assign dst[i]  = head[i][DATA_WIDTH+DST_LSB +: DST_WIDTH];
        assign drop[i] = !empty[i] && ({1'b0, dst[i]} >= (DST_WIDTH+1)'(NUM_OUT));
    end

    // A held output (valid, not accepted) is not free, so its requesters stay queued
    assign free = ~out_wr | out_rdy;

    always_comb begin
        req = '0;
        for (int j = 0; j < NUM_OUT; j++)
            for (int i = 0; i < NUM_IN; i++)
                req[j][i] = !empty[i] && ({1'b0, dst[i]} == (DST_WIDTH+1)'(j));
    end

    always_comb begin
        gnt_any = '0;
        gnt_idx = '0;
        for (int j = 0; j < NUM_OUT; j++)
            for (int k = 0; k < NUM_IN; k++)
                if (free[j] && !gnt_any[j] && req[j][wrap(rr_ptr[j], k)]) begin
                    gnt_any[j] = 1'b1;
                    gnt_idx[j] = wrap(rr_ptr[j], k);
                end
    end

    always_comb begin
        pop   = drop;
        ndrop = '0;
        for (int j = 0; j < NUM_OUT; j++)
            if (gnt_any[j]) pop[gnt_idx[j]] = 1'b1;
        for (int i = 0; i < NUM_IN; i++)
            ndrop = ndrop + 16'(drop[i]);
    end

    assign drop_sum = {1'b0, drop_cnt} + {1'b0, ndrop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_wr   <= '0;
            out_q    <= '0;
            rr_ptr   <= '0;
            drop_cnt <= '0;
        end else begin
            for (int j = 0; j < NUM_OUT; j++) begin
                if (gnt_any[j]) begin
                    out_wr[j] <= 1'b1;
                    out_q[j]  <= head[gnt_idx[j]];
                    rr_ptr[j] <= wrap(gnt_idx[j], 1);
                end else if (free[j]) begin
                    out_wr[j] <= 1'b0;
                end
            end
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
        assign out_ctl[j*CTRL_WIDTH +: CTRL_WIDTH]  = out_q[j][W-1 -: CTRL_WIDTH];
        assign out_data[j*DATA_WIDTH +: DATA_WIDTH] = out_q[j][DATA_WIDTH-1:0];
    end
endmodule

// File: tb/tb_ndp_xbar_rr.sv
// Bench for ndp_xbar_rr: 4x8 build checked every cycle against a queue-based model,
// plus a 4x6 build exercising invalid-destination drops via a vector table.

module tb_ndp_xbar_rr;
    localparam int DW = 480, CW = 32, NI = 4, NO = 8, NO6 = 6, D = 4;
    typedef logic [CW+DW-1:0] word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NI-1:0]     in_valid;
    logic [NI*CW-1:0]  in_ctl;
    logic [NI*DW-1:0]  in_data;
    logic [NI-1:0]     in_rdy;
    logic [NO-1:0]     out_rdy, out_wr;
    logic [NO*CW-1:0]  out_ctl;
    logic [NO*DW-1:0]  out_data;
    logic [15:0]       drop_cnt;

    logic [NI-1:0]     v6;
    logic [NI*CW-1:0]  c6;
    logic [NI*DW-1:0]  d6;
    logic [NI-1:0]     r6;
    logic [NO6-1:0]    or6, w6;
    logic [NO6*CW-1:0] oc6;
    logic [NO6*DW-1:0] od6;
    logic [15:0]       dc6;

    ndp_xbar_rr #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_IN(NI), .NUM_OUT(NO),
                  .DST_LSB(0), .DST_WIDTH(3), .FIFO_DEPTH_BITS(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctl(in_ctl), .in_data(in_data),
        .in_rdy(in_rdy), .out_rdy(out_rdy), .out_wr(out_wr), .out_ctl(out_ctl),
        .out_data(out_data), .drop_cnt(drop_cnt));

    ndp_xbar_rr #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_IN(NI), .NUM_OUT(NO6),
                  .DST_LSB(0), .DST_WIDTH(3), .FIFO_DEPTH_BITS(2)) u_dut6 (
        .clk(clk), .rst(rst), .in_valid(v6), .in_ctl(c6), .in_data(d6),
        .in_rdy(r6), .out_rdy(or6), .out_wr(w6), .out_ctl(oc6),
        .out_data(od6), .drop_cnt(dc6));

    int n_vec = 0, n_err = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] mk_ctl(input int src, input int seq, input int dst);
        return {16'(seq), 4'(src), 9'd0, 3'(dst)};
    endfunction

    function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
        return {15{~c}};
    endfunction

    task automatic set_in(input int i, input logic [CW-1:0] c);
        in_valid[i] = 1'b1;
        in_ctl[i*CW +: CW] = c;
        in_data[i*DW +: DW] = mk_data(c);
    endtask

    task automatic set6(input int i, input logic [CW-1:0] c);
        v6[i] = 1'b1;
        c6[i*CW +: CW] = c;
        d6[i*DW +: DW] = mk_data(c);
    endtask

    // Reference model: per-input word queues, one output slot per port, a
    // round-robin "next to look at" index per output.
    word_t       mq [NI][$];
    logic [NO-1:0] m_wr;
    word_t       m_q [NO];
    int          m_rr [NO];
    int          m_g [NO];
    bit          m_pop [NI];
    bit          m_full [NI];
    int          m_drop, m_nd, m_dd, m_s;
    word_t       m_hw;

    function automatic int head_dst(input word_t w);
        return int'(w[DW+2:DW]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NI; i++) mq[i].delete();
            for (int j = 0; j < NO; j++) begin m_q[j] = '0; m_rr[j] = 0; end
            m_wr = '0;
            m_drop = 0;
        end else begin
            m_nd = 0;
            for (int i = 0; i < NI; i++) begin
                m_pop[i] = 0;
                m_full[i] = (mq[i].size() == D);
                if (mq[i].size() > 0) begin
                    m_hw = mq[i][0];
                    if (head_dst(m_hw) >= NO) begin m_pop[i] = 1; m_nd++; end
                end
            end
            for (int j = 0; j < NO; j++) begin
                m_g[j] = -1;
                if (!m_wr[j] || out_rdy[j])
                    for (int k = 0; k < NI; k++) begin
                        m_s = (m_rr[j] + k) % NI;
                        if (m_g[j] < 0 && mq[m_s].size() > 0) begin
                            m_hw = mq[m_s][0];
                            if (head_dst(m_hw) == j) m_g[j] = m_s;
                        end
                    end
                if (m_g[j] >= 0) begin
                    m_q[j] = mq[m_g[j]][0];
                    m_wr[j] = 1'b1;
                    m_pop[m_g[j]] = 1;
                    m_rr[j] = (m_g[j] + 1) % NI;
                end else if (!m_wr[j] || out_rdy[j]) begin
                    m_wr[j] = 1'b0;
                end
            end
            for (int i = 0; i < NI; i++) begin
                if (m_pop[i]) void'(mq[i].pop_front());
                if (in_valid[i] && !m_full[i])
                    mq[i].push_back({in_ctl[i*CW +: CW], in_data[i*DW +: DW]});
            end
            m_drop = (m_drop + m_nd > 65535) ? 65535 : m_drop + m_nd;
        end
    end

    logic [NI-1:0] m_rdy;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) m_rdy[i] = (mq[i].size() < D-1);
            chk("m_in_rdy", in_rdy, m_rdy);
            chk("m_out_wr", out_wr, m_wr);
            chk("m_drop", drop_cnt, 16'(m_drop));
            for (int j = 0; j < NO; j++)
                if (m_wr[j]) begin
                    chk($sformatf("m_ctl%0d", j), out_ctl[j*CW +: CW], m_q[j][CW+DW-1:DW]);
                    chk($sformatf("m_data%0d", j), out_data[j*DW +: DW], m_q[j][DW-1:0]);
                end
        end
    end

    // Words accepted downstream, per output, in arrival order
    logic [CW-1:0] acc [NO][$];
    always @(negedge clk) begin
        if (!rst)
            for (int j = 0; j < NO; j++)
                if (out_wr[j] && out_rdy[j]) acc[j].push_back(out_ctl[j*CW +: CW]);
    end

    typedef struct {
        int             src;
        int             dst;
        logic [NO6-1:0] exp_wr;
        int             exp_drop;
    } vec_t;
    vec_t tbl [6];

    logic [CW-1:0] c_a, c_b;
    int sent, seq [NI], cnt [NI];

    initial begin
        tbl[0] = '{0, 0, 6'h01, 0};
        tbl[1] = '{1, 5, 6'h20, 0};
        tbl[2] = '{3, 6, 6'h00, 1};
        tbl[3] = '{2, 7, 6'h00, 2};
        tbl[4] = '{2, 3, 6'h08, 2};
        tbl[5] = '{3, 1, 6'h02, 2};

        in_valid = '0; in_ctl = '0; in_data = '0; out_rdy = '1;
        v6 = '0; c6 = '0; d6 = '0; or6 = '1;
        chk_en = 1;
        tick; tick;
        chk("rst_out_wr", out_wr, '0);
        chk("rst_drop", drop_cnt, '0);
        chk("rst_in_rdy", in_rdy, 4'hF);
        rst = 1'b0;
        tick;

        // Routing / drop table on the 6-output build
        for (int t = 0; t < 6; t++) begin
            c_a = mk_ctl(tbl[t].src, 300 + t, tbl[t].dst);
            set6(tbl[t].src, c_a);
            tick;
            v6 = '0;
            tick;
            chk($sformatf("tbl%0d_wr", t), w6, tbl[t].exp_wr);
            chk($sformatf("tbl%0d_drop", t), dc6, 16'(tbl[t].exp_drop));
            if (tbl[t].exp_wr != '0)
                chk($sformatf("tbl%0d_ctl", t), oc6[tbl[t].dst*CW +: CW], c_a);
            tick;
        end

        // Invalid dst followed back-to-back by a valid word
        c_a = mk_ctl(3, 400, 6);
        c_b = mk_ctl(3, 401, 2);
        set6(3, c_a); tick;
        set6(3, c_b); tick;
        v6 = '0;
        chk("t5_wr_drop", w6, '0);
        chk("t5_drop", dc6, 16'd3);
        tick;
        chk("t5_wr", w6, 6'h04);
        chk("t5_ctl", oc6[2*CW +: CW], c_b);
        chk("t5_data", od6[2*DW +: DW], mk_data(c_b));

        // Four inputs to four outputs in one cycle
        for (int i = 0; i < NI; i++) set_in(i, mk_ctl(i, 10 + i, i));
        tick;
        in_valid = '0;
        chk("t2_lat", out_wr, '0);
        tick;
        chk("t2_wr", out_wr, 8'h0F);
        for (int i = 0; i < NI; i++)
            chk($sformatf("t2_data%0d", i), out_data[i*DW +: DW], mk_data(mk_ctl(i, 10 + i, i)));
        repeat (3) tick;

        // All inputs stream to output 5
        for (int j = 0; j < NO; j++) acc[j].delete();
        for (int i = 0; i < NI; i++) begin seq[i] = 0; cnt[i] = 0; end
        for (int c = 0; c < 70; c++) begin
            for (int i = 0; i < NI; i++)
                if (in_rdy[i]) begin set_in(i, mk_ctl(i, seq[i], 5)); seq[i]++; end
                else in_valid[i] = 1'b0;
            tick;
            if (c >= 1) chk("t3_wr5", out_wr[5], 1'b1);
        end
        in_valid = '0;
        repeat (20) tick;
        chk("t3_count", acc[5].size() >= 64, 1'b1);
        for (int k = 0; k < 64 && k < acc[5].size(); k++) begin
            chk($sformatf("t3_order%0d", k), acc[5][k][15:12], 4'(k % NI));
            cnt[acc[5][k][15:12]]++;
        end
        for (int i = 0; i < NI; i++) chk($sformatf("t3_share%0d", i), cnt[i] >= 15 && cnt[i] <= 17, 1'b1);

        // Backpressure on output 2
        acc[2].delete();
        out_rdy[2] = 1'b0;
        sent = 0;
        for (int c = 0; c < 10; c++) begin
            if (sent < 6 && in_rdy[1]) begin set_in(1, mk_ctl(1, sent, 2)); sent++; end
            else in_valid[1] = 1'b0;
            tick;
            if (c >= 1) begin
                chk("t4_hold_wr", out_wr[2], 1'b1);
                chk("t4_hold_data", out_data[2*DW +: DW], mk_data(mk_ctl(1, 0, 2)));
            end
        end
        chk("t4_in_rdy", in_rdy[1], 1'b0);
        chk("t4_sent", sent, 4);
        out_rdy[2] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (sent < 6 && in_rdy[1]) begin set_in(1, mk_ctl(1, sent, 2)); sent++; end
            else in_valid[1] = 1'b0;
            tick;
        end
        in_valid = '0;
        repeat (3) tick;
        chk("t4_count", acc[2].size(), 6);
        for (int k = 0; k < 6 && k < acc[2].size(); k++)
            chk($sformatf("t4_word%0d", k), acc[2][k], mk_ctl(1, k, 2));

        // Overflow into a blocked FIFO
        acc[4].delete();
        out_rdy[4] = 1'b0;
        set_in(1, mk_ctl(1, 100, 4));
        tick;
        in_valid = '0;
        tick;
        for (int n = 0; n < 5; n++) begin set_in(0, mk_ctl(0, 200 + n, 4)); tick; end
        in_valid = '0;
        chk("t6_in_rdy", in_rdy[0], 1'b0);
        tick;
        out_rdy[4] = 1'b1;
        repeat (10) tick;
        chk("t6_count", acc[4].size(), 5);
        if (acc[4].size() == 5) begin
            chk("t6_blocker", acc[4][0], mk_ctl(1, 100, 4));
            for (int k = 0; k < 4; k++) chk($sformatf("t6_word%0d", k), acc[4][k+1], mk_ctl(0, 200 + k, 4));
        end

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NI; i++)
                if (($urandom % 3 != 0) && (in_rdy[i] || $urandom % 8 == 0))
                    set_in(i, mk_ctl(i, c, ($urandom % 2) ? int'($urandom % 3) : int'($urandom % NO)));
                else in_valid[i] = 1'b0;
            for (int j = 0; j < NO; j++) out_rdy[j] = ($urandom % 4 != 0);
            tick;
        end

        // Reset in the middle of traffic
        rst = 1'b1;
        #1;
        chk("t1_wr_async", out_wr, '0);
        chk("t1_drop", drop_cnt, '0);
        in_valid = '0;
        out_rdy = '1;
        tick; tick;
        rst = 1'b0;
        tick;
        chk("t1_in_rdy", in_rdy, 4'hF);
        chk("t1_wr", out_wr, '0);
        for (int c = 0; c < 6; c++) begin
            tick;
            chk("t1_stale", out_wr, '0);
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
